// File: rtl/pattern_player.sv
// pattern_player: buffers 2-bit Simon colours and plays them as timed on/off command strobes.
// Optional feature macro PATTERN_REPLAY_EN: retain entries and replay them from index 0 on every start.
module pattern_player #(
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             wr_color,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done,
    output logic                   flash_led,
    output logic                   play_audio,
    output logic [1:0]             color,
    output logic                   on_off
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef PATTERN_REPLAY_EN
    localparam bit ABORT_FLUSH = 1'b0;
`else
    localparam bit ABORT_FLUSH = 1'b1;
`endif

    typedef enum logic [2:0] {IDLE, ON_CMD, HOLD, OFF_CMD, GAP, DONE, ABORT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, rd_idx;
    logic [CW-1:0]    count_q, count_d, count_wr;
    logic             overflow_q, overflow_d, full_q, full_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             strobe_q, strobe_d, on_off_q, on_off_d;
    logic [1:0]       color_q, color_d;
    logic [1:0]       mem_q [DEPTH];
    logic             wr_acc, pop, flush, more;
`ifdef PATTERN_REPLAY_EN
    logic [CW-1:0]    play_q, play_d;
`endif

    always_comb begin
        wr_acc     = wr_en && !full_q;
        count_wr   = count_q + CW'(wr_acc);
        state_d    = state_q;
        timer_d    = timer_q;
        overflow_d = overflow_q | (wr_en & full_q);
        done_d     = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        more       = 1'b0;
`ifdef PATTERN_REPLAY_EN
        play_d     = play_q;
`endif

        case (state_q)
            IDLE: begin
                if (abort) begin
                    flush = ABORT_FLUSH;
                end else if (start) begin
                    if (count_q != '0) begin
                        state_d = ON_CMD;
`ifdef PATTERN_REPLAY_EN
                        play_d  = '0;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (clear) begin
                    flush      = 1'b1;
                    overflow_d = 1'b0;
                end
            end
            ON_CMD: begin
                if (abort) begin
                    state_d = ABORT;
                    flush   = ABORT_FLUSH;
                end else begin
                    state_d = HOLD;
                    timer_d = CNT_W'(ON_CYCLES - 1);
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = ABORT;
                    flush   = ABORT_FLUSH;
                end else if (timer_q == '0) begin
                    state_d = OFF_CMD;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            OFF_CMD: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = ABORT_FLUSH;
                end else begin
                    // A write landing in this same cycle still counts as a remaining entry
`ifdef PATTERN_REPLAY_EN
                    play_d = play_q + CW'(1);
                    more   = count_wr > play_d;
`else
                    pop    = 1'b1;
                    more   = count_wr > CW'(1);
`endif
                    if (more) begin
                        state_d = GAP;
                        timer_d = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = ABORT_FLUSH;
                end else if (timer_q == '0) begin
                    state_d = ON_CMD;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                flush   = abort & ABORT_FLUSH;
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tail_d = wr_acc ? tail_q + PW'(1) : tail_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = CW'(wr_acc);
        end else begin
            head_d  = pop ? head_q + PW'(1) : head_q;
            count_d = count_q + CW'(wr_acc) - CW'(pop);
        end

`ifdef PATTERN_REPLAY_EN
        rd_idx = head_q + play_d[PW-1:0];
`else
        rd_idx = head_q;
`endif

        // Outputs are registered alongside the state they belong to
        strobe_d = (state_d == ON_CMD) || (state_d == OFF_CMD) || (state_d == ABORT);
        on_off_d = (state_d == ON_CMD);
        color_d  = (state_d == ON_CMD) ? mem_q[rd_idx] : color_q;
        busy_d   = (state_d != IDLE);
        full_d   = (count_d == CW'(DEPTH));
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
            on_off_q   <= 1'b0;
            color_q    <= 2'b00;
`ifdef PATTERN_REPLAY_EN
            play_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            strobe_q   <= strobe_d;
            on_off_q   <= on_off_d;
            color_q    <= color_d;
`ifdef PATTERN_REPLAY_EN
            play_q     <= play_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[tail_q] <= wr_color;
        end
    end

    assign count      = count_q;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign flash_led  = strobe_q;
    assign play_audio = strobe_q;
    assign color      = color_q;
    assign on_off     = on_off_q;

endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: scoreboard bench for pattern_player (DEPTH=4, ON_CYCLES=3, GAP_CYCLES=2).
// Expected strobe/done events are queued when start is driven and popped as the DUT emits them.
module tb_pattern_player;
    localparam int DEPTH  = 4;
    localparam int ON     = 3;
    localparam int GAP    = 2;
    localparam int PERIOD = ON + GAP + 2;
`ifdef PATTERN_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_color = 2'b00;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] count;
    logic       full, overflow, busy, done, flash_led, play_audio, on_off;
    logic [1:0] color;

    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int passes = 0;
    int exp_q[$];

    pattern_player #(
        .DEPTH(DEPTH), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .CNT_W(8)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_color(wr_color),
        .start(start), .abort(abort), .clear(clear), .count(count),
        .full(full), .overflow(overflow), .busy(busy), .done(done),
        .flash_led(flash_led), .play_audio(play_audio), .color(color), .on_off(on_off)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // kind: 1 = on strobe, 2 = off strobe, 3 = done pulse; offset is cycles relative to the start edge
    function automatic int ev(input int kind, input int col, input int off);
        return (kind << 16) | (col << 8) | off;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] c, input logic s,
                                 input logic a, input logic cl);
        wr_en = w; wr_color = c; start = s; abort = a; clear = cl;
        if (s) t0 = cyc + 1;
        @(negedge clock);
        wr_en = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0;
    endtask

    task automatic pushTrain(input int n, input logic [7:0] cols);
        for (int i = 0; i < n; i++) begin
            logic [1:0] c;
            c = cols[2*i +: 2];
            exp_q.push_back(ev(1, int'(c), 1 + i * PERIOD));
            exp_q.push_back(ev(2, int'(c), 2 + ON + i * PERIOD));
        end
        exp_q.push_back(ev(3, 0, (n == 0) ? 1 : 3 + ON + (n - 1) * PERIOD));
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clock) begin
        int obs;
        int expv;
        if (reset && (flash_led || play_audio || done)) begin
            obs = flash_led ? ev(on_off ? 1 : 2, int'(color), cyc - t0 + 1)
                            : ev(3, 0, cyc - t0 + 1);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", obs, 0);
            end else begin
                expv = exp_q.pop_front();
                checkOutput("event", obs, expv);
                checkOutput("play_audio", int'(play_audio), ((expv >> 16) != 3) ? 1 : 0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_flash", flash_led, 0);
        checkOutput("rst_on_off", on_off, 0);
        checkOutput("rst_color", color, 0);
        reset = 1'b1;
        @(negedge clock);

        // Two colours, played end to end
        applyStimulus(1, 2'b01, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0);
        checkOutput("count_two", count, 2);
        pushTrain(2, 8'b0000_1001);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("busy_running", busy, 1);
        waitDrain(40);
        checkOutput("count_after_two", count, REPLAY ? 2 : 0);
        checkOutput("busy_after_two", busy, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Overfill: fifth colour dropped and never played
        applyStimulus(1, 2'b00, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0);
        applyStimulus(1, 2'b11, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0);
        checkOutput("count_full", count, 4);
        checkOutput("full_flag", full, 1);
        checkOutput("overflow_flag", overflow, 1);
        pushTrain(4, 8'b1110_0100);
        applyStimulus(0, 0, 1, 0, 0);
        waitDrain(60);
        checkOutput("count_after_four", count, REPLAY ? 4 : 0);
        checkOutput("overflow_sticky", overflow, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("overflow_cleared", overflow, 0);
        checkOutput("count_cleared", count, 0);

        // Empty start: done one cycle later, never busy
        pushTrain(0, 8'h00);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("busy_empty_start", busy, 0);
        waitDrain(10);
        checkOutput("busy_after_empty", busy, 0);

        // Abort in HOLD of colour 11
        applyStimulus(1, 2'b11, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 0);
        exp_q.push_back(ev(1, 3, 1));
        exp_q.push_back(ev(2, 3, 3));
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clock);
        applyStimulus(0, 0, 0, 1, 0);
        waitDrain(10);
        checkOutput("busy_after_abort", busy, 0);
        checkOutput("count_after_abort", count, REPLAY ? 2 : 0);
        applyStimulus(0, 0, 0, 0, 1);

`ifdef PATTERN_REPLAY_EN
        // Replay the same two entries twice
        applyStimulus(1, 2'b00, 0, 0, 0);
        applyStimulus(1, 2'b11, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            pushTrain(2, 8'b0000_1100);
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("replay_count_run", count, 2);
            waitDrain(40);
            checkOutput("replay_count_idle", count, 2);
        end
        applyStimulus(0, 0, 0, 0, 1);
`endif

        // Asynchronous reset in the middle of a gap
        applyStimulus(1, 2'b10, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0);
        exp_q.push_back(ev(1, 2, 1));
        exp_q.push_back(ev(2, 2, 2 + ON));
        applyStimulus(0, 0, 1, 0, 0);
        repeat (5) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("midgap_events_seen", exp_q.size(), 0);
        exp_q.delete();
        checkOutput("midgap_count", count, 0);
        checkOutput("midgap_busy", busy, 0);
        checkOutput("midgap_flash", flash_led, 0);
        checkOutput("midgap_color", color, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pushTrain(0, 8'h00);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("busy_after_reset_start", busy, 0);
        waitDrain(10);
        applyStimulus(1, 2'b11, 0, 0, 0);
        pushTrain(1, 8'b0000_0011);
        applyStimulus(0, 0, 1, 0, 0);
        waitDrain(20);
        checkOutput("count_after_recover", count, REPLAY ? 1 : 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
